tone_synth: RTL and testbench

- Parametrised multi-channel tone synthesiser feeding the audio PCM FIFO.
- Each channel runs its own phase accumulator at a fixed sample rate derived from clk.
- All channels share a waveform select (square, sawtooth, triangle, DC) and an amplitude.
- Packed samples are pushed one word per sample period; the block honours FIFO backpressure and flags dropped sample periods.

---
 rtl/tone_synth.sv | 108 ++++++++++
 tb/tb_tone_synth.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tone_synth.sv
// Multi-channel phase-accumulator tone synthesiser with a fixed sample timer.
// Pushes one packed PCM word per sample period into a downstream FIFO.
module tone_synth #(
  parameter int unsigned CH_W     = 8,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned PHASE_W  = 24,
  parameter int unsigned RATE_DIV = 1024
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      enable,
  input  logic                      fifo_full,
  input  logic [NUM_CH*PHASE_W-1:0] freq_word,
  input  logic [1:0]                wave_sel,
  input  logic [CH_W-1:0]           amplitude,
  input  logic                      clr_overrun,
  output logic                      tone_pcm_rdy,
  output logic [NUM_CH*CH_W-1:0]    tone_pcm,
  output logic                      overrun
);

  localparam int unsigned TMR_W  = $clog2(RATE_DIV);
  localparam int unsigned PCM_W  = NUM_CH * CH_W;
  localparam int unsigned PROD_W = 2 * CH_W;

  typedef enum logic [1:0] {IDLE, CALC, PUSH} state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic               tick;
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [PCM_W-1:0]   sample_c;
  logic [CH_W-1:0]    raw;
  logic [CH_W-1:0]    shaped;
  logic [PROD_W-1:0]  prod;

  assign tick = enable && (timer == TMR_W'(RATE_DIV - 1));

  // The strobe must follow fifo_full within the same cycle, so it is decoded from the state.
  assign tone_pcm_rdy = (state == PUSH) && !fifo_full;

  // Sample-period timer; frozen while disabled.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      timer <= '0;
    end else if (enable) begin
      timer <= tick ? '0 : timer + TMR_W'(1);
    end
  end

  // Waveform shaping and amplitude scaling for every channel.
  always_comb begin
    sample_c = '0;
    raw      = '0;
    shaped   = '0;
    prod     = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      raw = phase[n][PHASE_W-1 -: CH_W];
      case (wave_sel)
        2'd0:    shaped = raw[CH_W-1] ? '1 : '0;
        2'd1:    shaped = raw;
        2'd2:    shaped = raw[CH_W-1] ? ~{raw[CH_W-2:0], 1'b0} : {raw[CH_W-2:0], 1'b0};
        default: shaped = '1;
      endcase
      prod = PROD_W'(shaped) * PROD_W'(amplitude);
      sample_c[n*CH_W +: CH_W] = prod[PROD_W-1 -: CH_W];
    end
  end

  // Accumulate on tick, latch shaped samples, then wait for FIFO space.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      tone_pcm <= '0;
      overrun  <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        phase[n] <= '0;
      end
    end else begin
      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
              phase[n] <= phase[n] + freq_word[n*PHASE_W +: PHASE_W];
            end
            state <= CALC;
          end
        end
        CALC: begin
          tone_pcm <= sample_c;
          state    <= PUSH;
        end
        PUSH: begin
          if (!fifo_full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_synth.sv
// Bench for tone_synth: directed scenarios plus random traffic, each cycle
// compared against a sample-level reference model.
module tb_tone_synth;

  localparam int unsigned CH_W     = 8;
  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned PHASE_W  = 16;
  localparam int unsigned RATE_DIV = 4;

  logic        clk = 1'b0;
  logic        aclr;
  logic        enable;
  logic        fifo_full;
  logic [31:0] freq_word;
  logic [1:0]  wave_sel;
  logic [7:0]  amplitude;
  logic        clr_overrun;
  logic        tone_pcm_rdy;
  logic [15:0] tone_pcm;
  logic        overrun;

  tone_synth #(
    .CH_W(CH_W), .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .RATE_DIV(RATE_DIV)
  ) dut (
    .clk(clk), .aclr(aclr), .enable(enable), .fifo_full(fifo_full),
    .freq_word(freq_word), .wave_sel(wave_sel), .amplitude(amplitude),
    .clr_overrun(clr_overrun), .tone_pcm_rdy(tone_pcm_rdy),
    .tone_pcm(tone_pcm), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] push_q[$];
  int          push_cyc[$];

  // Reference state: sample timer, phases, pending-sample age (-1 none, 0 computing, 1 waiting).
  int unsigned m_timer;
  int unsigned m_ph [2];
  int          m_age;
  logic [15:0] m_pcm;
  logic        m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tone(input int unsigned ph, input logic [1:0] ws, input logic [7:0] amp);
    int unsigned r = ph / 256;
    int unsigned s;
    case (ws)
      2'd0:    s = (r >= 128) ? 255 : 0;
      2'd1:    s = r;
      2'd2:    s = (r < 128) ? 2 * r : 255 - 2 * (r - 128);
      default: s = 255;
    endcase
    return 8'((s * amp) / 256);
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_ph[0] = 0;
    m_ph[1] = 0;
    m_age   = -1;
    m_pcm   = '0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step();
    bit tk = enable && (m_timer == RATE_DIV - 1);
    if (tk && m_age != -1) m_ovr = 1'b1;
    else if (clr_overrun)  m_ovr = 1'b0;
    if (m_age == -1 && tk) begin
      m_ph[0] = (m_ph[0] + freq_word[15:0])  % 65536;
      m_ph[1] = (m_ph[1] + freq_word[31:16]) % 65536;
      m_age = 0;
    end else if (m_age == 0) begin
      m_pcm = {tone(m_ph[1], wave_sel, amplitude), tone(m_ph[0], wave_sel, amplitude)};
      m_age = 1;
    end else if (m_age == 1 && !fifo_full) begin
      m_age = -1;
    end
    if (enable) m_timer = (m_timer + 1) % RATE_DIV;
  endtask

  task automatic cycle();
    @(negedge clk);
    check("rdy", 32'(tone_pcm_rdy), 32'(m_age == 1 && !fifo_full));
    check("pcm", 32'(tone_pcm), 32'(m_pcm));
    check("ovr", 32'(overrun), 32'(m_ovr));
    if (tone_pcm_rdy === 1'b1) begin
      push_q.push_back(tone_pcm);
      push_cyc.push_back(cyc);
    end
    if (!aclr) model_step();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    aclr = 1'b1;
    model_reset();
    repeat (n) cycle();
    aclr = 1'b0;
    push_q.delete();
    push_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    aclr = 1'b1; enable = 1'b0; fifo_full = 1'b0; clr_overrun = 1'b0;
    freq_word = '0; wave_sel = 2'd1; amplitude = 8'hFF;

    // Reset and idle with synthesis disabled
    apply_reset(3);
    repeat (20) cycle();
    check("idle_pushes", 32'(push_q.size()), 0);
    check("idle_pcm", 32'(tone_pcm), 0);

    // Sawtooth, both channels, full amplitude
    apply_reset(1);
    wave_sel = 2'd1; amplitude = 8'hFF; freq_word = 32'h2000_1000; enable = 1'b1;
    repeat (66) cycle();
    check("saw_count", 32'(push_q.size()), 16);
    if (push_q.size() >= 16) begin
      check("saw_first_cyc", 32'(push_cyc[0]), 5);
      check("saw_period", 32'(push_cyc[1] - push_cyc[0]), 4);
      check("saw_s1", 32'(push_q[0]), 32'h1F0F);
      check("saw_s2", 32'(push_q[1]), 32'h3F1F);
      check("saw_wrap", 32'(push_q[15]), 32'h0000);
    end

    // Square at half amplitude
    apply_reset(2);
    wave_sel = 2'd0; amplitude = 8'h80; freq_word = 32'h0000_4000; enable = 1'b1;
    repeat (18) cycle();
    check("sq_count", 32'(push_q.size()), 4);
    if (push_q.size() >= 4) begin
      check("sq_0", 32'(push_q[0]), 32'h0000);
      check("sq_1", 32'(push_q[1]), 32'h007F);
      check("sq_2", 32'(push_q[2]), 32'h007F);
      check("sq_3", 32'(push_q[3]), 32'h0000);
    end

    // DC
    apply_reset(2);
    wave_sel = 2'd3; enable = 1'b1;
    repeat (6) cycle();
    check("dc_count", 32'(push_q.size()), 1);
    if (push_q.size() >= 1) check("dc_0", 32'(push_q[0]), 32'h7F7F);

    // Triangle
    apply_reset(2);
    wave_sel = 2'd2; enable = 1'b1;
    repeat (6) cycle();
    check("tri_count", 32'(push_q.size()), 1);
    if (push_q.size() >= 1) check("tri_0", 32'(push_q[0]), 32'h0040);

    // Backpressure, then overrun with clear and same-cycle clear/set
    apply_reset(2);
    wave_sel = 2'd1; amplitude = 8'hFF; freq_word = 32'h2000_1000; enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      fifo_full   = (i >= 3 && i <= 5) || (i >= 8 && i <= 17) || (i >= 24 && i <= 27);
      clr_overrun = (i == 22) || (i == 27);
      if (i == 7)  check("bp_no_ovr", 32'(overrun), 0);
      if (i == 12) check("ovr_set", 32'(overrun), 1);
      if (i == 23) check("ovr_clr", 32'(overrun), 0);
      if (i == 28) check("ovr_set_wins", 32'(overrun), 1);
      cycle();
    end
    fifo_full = 1'b0; clr_overrun = 1'b0;
    check("ovr_count", 32'(push_q.size()), 4);
    if (push_q.size() >= 4) begin
      check("bp_cyc", 32'(push_cyc[0]), 6);
      check("bp_pcm", 32'(push_q[0]), 32'h1F0F);
      check("stall_cyc", 32'(push_cyc[1]), 18);
      check("stall_pcm", 32'(push_q[1]), 32'h3F1F);
      check("after_stall", 32'(push_q[2]), 32'h5F2F);
      check("after_drop", 32'(push_q[3]), 32'h7F3F);
    end

    // Async reset while a push is stalled
    apply_reset(2);
    enable = 1'b1; fifo_full = 1'b1;
    repeat (7) cycle();
    check("pre_rst_pcm", 32'(tone_pcm), 32'h1F0F);
    aclr = 1'b1;
    #1;
    check("rst_rdy", 32'(tone_pcm_rdy), 0);
    check("rst_pcm", 32'(tone_pcm), 0);
    check("rst_ovr", 32'(overrun), 0);
    apply_reset(2);
    fifo_full = 1'b0;
    repeat (6) cycle();
    check("rst_count", 32'(push_q.size()), 1);
    if (push_q.size() >= 1) check("rst_restart", 32'(push_q[0]), 32'h1F0F);

    // Random traffic against the model
    apply_reset(2);
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) wave_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) amplitude = 8'($urandom);
      if ($urandom_range(0, 49) == 0) freq_word = 32'($urandom);
      enable      = ($urandom_range(0, 9) != 0);
      fifo_full   = ($urandom_range(0, 3) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      cycle();
    end
    check("rand_pushes", 32'(push_q.size() > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
